ctrl_sumador_serie: RTL and testbench
=====================================

CTRL_SUMADOR_SERIE -- requirements
Module: ctrl_sumador_serie

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 Port: op  input  1  0 = add (a+b), 1 = subtract (a-b, two's complement); sampled with start.
REQ-006 Port: a  input  WIDTH  first operand; sampled with start.
REQ-007 Port: b  input  WIDTH  second operand; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress (LOAD and ADD states).
REQ-009 Port: done  output  1  one-cycle pulse when suma/cout become valid.
REQ-010 Port: suma  output  WIDTH  result of last completed operation.
REQ-011 Port: cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned).

Function
REQ-012 The block SHALL compute the result bit-serially, LSB first, through a single 1-bit full-adder instance, one bit per clock.
REQ-013 The FSM SHALL have exactly four states: IDLE, LOAD, ADD, DONE.
REQ-014 IDLE -> LOAD when start=1; otherwise stay in IDLE.
REQ-015 LOAD (1 cycle): capture a into shift register A, b (inverted if op=1) into shift register B, carry flop = op, bit counter = 0, result shift register = 0; -> ADD.
REQ-016 ADD: each cycle the full-adder output bit SHALL be shifted into the result register at the MSB end, A and B shifted right by one, carry flop updated with the adder carry, counter incremented.
REQ-017 ADD -> DONE when the counter reaches WIDTH-1 and that bit has been processed, i.e. after exactly WIDTH ADD cycles.
REQ-018 DONE (1 cycle): suma and cout SHALL be loaded from the result register and carry flop, done=1; -> IDLE.
REQ-019 Latency: start sampled high on edge N, so done=1 and suma/cout valid during the cycle following edge N+WIDTH+2.
REQ-020 suma and cout SHALL hold their value from DONE until the next DONE or reset.
REQ-021 start SHALL be ignored in LOAD, ADD and DONE; a, b and op changes during an operation SHALL NOT affect the result.
REQ-022 If start is held high continuously, a new operation SHALL start in the IDLE cycle after DONE (throughput one result per WIDTH+3 cycles).
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; overflow is indicated only through cout.
REQ-024 busy SHALL be 0 in IDLE and DONE, 1 in LOAD and ADD; done SHALL be 0 in all states except DONE.

Reset
REQ-025 On rst=1 at a rising edge: state = IDLE, busy = 0, done = 0, suma = 0, cout = 0, counter = 0, carry flop = 0, shift registers = 0.
REQ-026 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-027 The cycle after rst deasserts, the block SHALL accept a start normally.

Structure
REQ-028 A shared package SHALL hold the state encoding constants (IDLE, LOAD, ADD, DONE; 2-bit) and the default WIDTH constant.
REQ-029 One sub-module SHALL be used: sum_completo_1b, a 1-bit full adder built from two medio_sum instances plus an OR for carry.
REQ-030 Counter width SHALL be ceil(log2(WIDTH)) bits; no other arithmetic operators beyond the counter increment are permitted in the controller.

Verification (WIDTH=8)
REQ-031 a=8'h05, b=8'h03, op=0, start pulse -> done pulses 10 cycles after the start edge, suma=8'h08, cout=0.
REQ-032 a=8'hFF, b=8'h01, op=0 -> suma=8'h00, cout=1.
REQ-033 a=8'h05, b=8'h07, op=1 -> suma=8'hFE, cout=0; a=8'h07, b=8'h05, op=1 -> suma=8'h02, cout=1.
REQ-034 Start op a=8'h10, b=8'h20; during ADD assert start with a=8'hAA, b=8'h55 -> single done, suma=8'h30, busy stays high until DONE.
REQ-035 rst asserted on the 4th ADD cycle -> next cycle busy=0, suma=8'h00, no done pulse; following start a=8'h01, b=8'h01 -> suma=8'h02.
REQ-036 start held high with a=8'h80, b=8'h80 -> done every 11 cycles, each suma=8'h00, cout=1.

Source files
------------

// File: rtl/ctrl_sumador_serie_pkg.sv
// Shared constants for the bit-serial adder/subtractor: state encoding and default width.
package ctrl_sumador_serie_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StAdd  = 2'd2,
      StDone = 2'd3
   } state_e;

endpackage

// File: rtl/ctrl_sumador_serie_if.sv
// Request/result bundle of the serial adder; master issues operations, slave computes them.
interface ctrl_sumador_serie_if
   import ctrl_sumador_serie_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] suma;
   logic             cout;

   modport master (
      output start, op, a, b,
      input  busy, done, suma, cout
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, suma, cout
   );

endinterface

// File: rtl/medio_sum.sv
// 1-bit half adder.
module medio_sum (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

// File: rtl/sum_completo_1b.sv
// 1-bit full adder from two half adders; carry out is the OR of both partial carries.
module sum_completo_1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s1, c1, c2;

   medio_sum u_ms0 (
      .x (a),
      .y (b),
      .s (s1),
      .c (c1)
   );

   medio_sum u_ms1 (
      .x (s1),
      .y (cin),
      .s (s),
      .c (c2)
   );

   assign cout = c1 | c2;

endmodule

// File: rtl/ctrl_sumador_serie.sv
// Bit-serial add/subtract controller: one result bit per clock through a single full adder,
// LSB first, result and carry published one cycle after the DONE state.
module ctrl_sumador_serie
   import ctrl_sumador_serie_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   ctrl_sumador_serie_if.slave bus
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q, suma_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, busy_q, done_q;
   logic             fa_s, fa_c;

   sum_completo_1b u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         suma_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Operands are latched on the accepting edge so later input changes are harmless.
               if (bus.start) begin
                  a_sr_q  <= bus.a;
                  b_sr_q  <= bus.op ? ~bus.b : bus.b;
                  carry_q <= bus.op;
                  busy_q  <= 1'b1;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               cnt_q   <= '0;
               res_q   <= '0;
               state_q <= StAdd;
            end
            StAdd: begin
               res_q   <= {fa_s, res_q[WIDTH-1:1]};
               a_sr_q  <= a_sr_q >> 1;
               b_sr_q  <= b_sr_q >> 1;
               carry_q <= fa_c;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CntLast) begin
                  busy_q  <= 1'b0;
                  state_q <= StDone;
               end
            end
            StDone: begin
               suma_q  <= res_q;
               cout_q  <= carry_q;
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.suma = suma_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_ctrl_sumador_serie.sv
// Directed bench for ctrl_sumador_serie at WIDTH=8 with hand-computed results.
module tb_ctrl_sumador_serie;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ndone;
   int   nxt;

   ctrl_sumador_serie_if #(.WIDTH(8)) bus ();

   ctrl_sumador_serie #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation from IDLE (caller is just after an edge) and check latency and result.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic top, input logic [7:0] es, input logic ec);
      int k;
      k = 0;
      bus.a = ta;
      bus.b = tb_;
      bus.op = top;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = ~ta;
      bus.b = ~tb_;
      bus.op = ~top;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!bus.done && k < 20);
      chk({tag, "_latency"}, k, 10);
      chk({tag, "_suma"}, bus.suma, es);
      chk({tag, "_cout"}, bus.cout, ec);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, bus.done, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_suma", bus.suma, 8'h00);
      chk("rst_cout", bus.cout, 1'b0);
      rst = 1'b0;

      run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
      run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
      run_op("sub_00_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
      run_op("add_aa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

      // start re-asserted with new operands mid-operation must be ignored
      bus.a = 8'h10;
      bus.b = 8'h20;
      bus.op = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (k <= 9) chk("busy_during_op", bus.busy, (k <= 8));
         if (bus.done) begin
            ndone++;
            chk("ignore_start_done_at", k, 10);
            chk("ignore_start_suma", bus.suma, 8'h30);
            chk("ignore_start_cout", bus.cout, 1'b0);
         end
         if (k == 2) begin
            bus.start = 1'b1;
            bus.a = 8'hAA;
            bus.b = 8'h55;
         end
         if (k == 8) bus.start = 1'b0;
      end
      chk("ignore_start_ndone", ndone, 1);

      // reset during the 4th ADD cycle aborts without a done pulse
      bus.a = 8'h3C;
      bus.b = 8'h0F;
      bus.op = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_busy_before", bus.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_suma", bus.suma, 8'h00);
      chk("abort_cout", bus.cout, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

      // start held high: one result every 11 cycles
      bus.a = 8'h80;
      bus.b = 8'h80;
      bus.op = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      nxt = 10;
      ndone = 0;
      for (int k = 1; k <= 35; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            ndone++;
            chk("stream_done_at", k, nxt);
            chk("stream_suma", bus.suma, 8'h00);
            chk("stream_cout", bus.cout, 1'b1);
            nxt += 11;
         end
      end
      bus.start = 1'b0;
      chk("stream_ndone", ndone, 3);
      repeat (15) @(posedge clk);
      #1;
      chk("final_idle_busy", bus.busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
